// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam logic        RstEnable   = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef enum logic [0:0] {
        IfFetch,
        IfHold
    } if_state_e;

    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache with combinational lookup,
// single-cycle fill and reset-clear of all valid bits.
module if_fetch_icache
    import if_fetch_pkg::*;
#(
    parameter int unsigned INDEX_W = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [InstAddrBus-1:0] lookup_addr,
    output logic                   lookup_hit,
    output logic [InstBus-1:0]     lookup_word,
    input  logic                   fill_en,
    input  logic [InstAddrBus-1:0] fill_addr,
    input  logic [InstBus-1:0]     fill_word
);

    localparam int unsigned Lines = 1 << INDEX_W;
    localparam int unsigned TagW  = InstAddrBus - INDEX_W - 2;

    logic [Lines-1:0]   valid_q;
    logic [TagW-1:0]    tag_q  [Lines];
    logic [InstBus-1:0] data_q [Lines];

    logic [INDEX_W-1:0] lookup_idx;
    logic [INDEX_W-1:0] fill_idx;
    logic               unused_bits;

    assign lookup_idx  = lookup_addr[INDEX_W+1:2];
    assign fill_idx    = fill_addr[INDEX_W+1:2];
    assign unused_bits = ^{lookup_addr[1:0], fill_addr[1:0]};

    assign lookup_hit  = valid_q[lookup_idx] &&
                         (tag_q[lookup_idx] == lookup_addr[InstAddrBus-1:INDEX_W+2]);
    assign lookup_word = data_q[lookup_idx];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_addr[InstAddrBus-1:INDEX_W+2];
            data_q[fill_idx] <= fill_word;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each word from four little-endian byte reads.
// Define ICACHE_EN to build the optional direct-mapped instruction cache.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned ICACHE_INDEX_W = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   stall_i,
    input  logic                   jump_i,
    input  logic [InstAddrBus-1:0] jump_addr_i,
    output logic                   mem_req_o,
    output logic [InstAddrBus-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [7:0]             mem_byte_i,
    output logic                   valid_o,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o
);

    if_state_e              state_q;
    logic [InstAddrBus-1:0] pc_q;
    logic [InstAddrBus-1:0] pc_out_q;
    logic [InstBus-1:0]     inst_q;
    logic [1:0]             byte_cnt_q;
    logic [23:0]            word_buf_q;
    logic                   valid_q;

    logic                   fetching;
    logic                   hit;
    logic [InstBus-1:0]     hit_word;
    logic [InstBus-1:0]     fetched_word;

    assign fetching     = (state_q == IfFetch);
    assign fetched_word = {mem_byte_i, word_buf_q};

`ifdef ICACHE_EN
    logic lookup_hit;
    logic fill_en;

    if_fetch_icache #(
        .INDEX_W(ICACHE_INDEX_W)
    ) u_icache (
        .clk        (clk),
        .rst        (rst),
        .lookup_addr(pc_q),
        .lookup_hit (lookup_hit),
        .lookup_word(hit_word),
        .fill_en    (fill_en),
        .fill_addr  (pc_q),
        .fill_word  (fetched_word)
    );

    assign hit     = fetching && (byte_cnt_q == 2'd0) && lookup_hit;
    assign fill_en = rdy && (rst != RstEnable) && !jump_i && fetching && !hit &&
                     mem_ack_i && (byte_cnt_q == 2'd3);
`else
    logic unused_cfg;

    assign unused_cfg = ^ICACHE_INDEX_W;
    assign hit        = 1'b0;
    assign hit_word   = ZeroWord;
`endif

    assign mem_req_o  = rdy && (rst != RstEnable) && fetching && !hit;
    assign mem_addr_o = (rst == RstEnable) ? ZeroWord : pc_q + {30'd0, byte_cnt_q};

    assign valid_o = valid_q;
    assign pc_o    = pc_out_q;
    assign inst_o  = inst_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= IfFetch;
            pc_q       <= ZeroWord;
            pc_out_q   <= ZeroWord;
            inst_q     <= ZeroWord;
            byte_cnt_q <= 2'd0;
            word_buf_q <= 24'd0;
            valid_q    <= 1'b0;
        end else if (rdy) begin
            if (jump_i) begin
                // Redirect wins over a same-cycle ack and over a stalled held word.
                state_q    <= IfFetch;
                pc_q       <= word_align(jump_addr_i);
                byte_cnt_q <= 2'd0;
                valid_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    IfFetch: begin
                        if (hit) begin
                            inst_q   <= hit_word;
                            pc_out_q <= pc_q;
                            valid_q  <= 1'b1;
                            state_q  <= IfHold;
                        end else if (mem_ack_i) begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            unique case (byte_cnt_q)
                                2'd0: word_buf_q[7:0]   <= mem_byte_i;
                                2'd1: word_buf_q[15:8]  <= mem_byte_i;
                                2'd2: word_buf_q[23:16] <= mem_byte_i;
                                default: begin
                                    inst_q   <= fetched_word;
                                    pc_out_q <= pc_q;
                                    valid_q  <= 1'b1;
                                    state_q  <= IfHold;
                                end
                            endcase
                        end
                    end
                    IfHold: begin
                        if (!stall_i) begin
                            pc_q    <= pc_q + 32'd4;
                            valid_q <= 1'b0;
                            state_q <= IfFetch;
                        end
                    end
                    default: state_q <= IfFetch;
                endcase
            end
        end
    end

endmodule
